// File: rtl/conv1d_2nd_data_ram_writer.sv
// Purpose: pool 2:1 (signed max, optional ReLU via POOL_RELU_EN) the layer-1 stream into the layer-2 data RAM.
// Latency: the RAM write is visible the cycle after the second sample of a pair; Done follows one cycle later.
// Backpressure: In_Ready is high for the whole frame; In_Valid low just holds state, and no writes occur in gaps.
module conv1d_2nd_data_ram_writer #(
    parameter int Bit_width    = 16,
    parameter int Num_Channels = 8,
    parameter int Out_Width    = 256
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 Start,
    input  logic                 In_Valid,
    input  logic [Bit_width-1:0] In_Data,
    output logic                 In_Ready,
    output logic                 Write_Enable,
    output logic [2:0]           Write_Depth,
    output logic [7:0]           Write_Width,
    output logic [Bit_width-1:0] Write_Data,
    output logic                 Busy,
    output logic                 Done
);

    localparam logic [2:0] LAST_CHAN = 3'(Num_Channels - 1);
    localparam logic [7:0] LAST_WID  = 8'(Out_Width - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           chan_q, chan_d;
    logic [7:0]           wid_q, wid_d;
    logic [Bit_width-1:0] held_q, held_d;
    logic                 we_q, we_d;
    logic [2:0]           depth_q, depth_d;
    logic [7:0]           width_q, width_d;
    logic [Bit_width-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready;
    logic [Bit_width-1:0] max_v;
    logic [Bit_width-1:0] pool_v;

    // Pooled value of the held sample and the incoming one; ties keep the held sample.
    always_comb begin
        max_v = ($signed(In_Data) > $signed(held_q)) ? In_Data : held_q;
`ifdef POOL_RELU_EN
        pool_v = max_v[Bit_width-1] ? '0 : max_v;
`else
        pool_v = max_v;
`endif
    end

    // Next-state, counter and write-port logic for the pairing FSM.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        wid_d   = wid_q;
        held_d  = held_q;
        we_d    = 1'b0;
        depth_d = depth_q;
        width_d = width_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    chan_d  = 3'd0;
                    wid_d   = 8'd0;
                    busy_d  = 1'b1;
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                ready = 1'b1;
                if (In_Valid) begin
                    held_d  = In_Data;
                    state_d = S_SECOND;
                end
            end
            S_SECOND: begin
                ready = 1'b1;
                if (In_Valid) begin
                    we_d    = 1'b1;
                    data_d  = pool_v;
                    depth_d = chan_q;
                    width_d = wid_q;
                    // Pairs never straddle channels, so the width wrap is the channel step.
                    if (wid_q == LAST_WID) begin
                        wid_d  = 8'd0;
                        chan_d = chan_q + 3'd1;
                    end else begin
                        wid_d = wid_q + 8'd1;
                    end
                    if ((chan_q == LAST_CHAN) && (wid_q == LAST_WID)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FIRST;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any half-pooled pair.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            chan_q  <= 3'd0;
            wid_q   <= 8'd0;
            held_q  <= '0;
            we_q    <= 1'b0;
            depth_q <= 3'd0;
            width_q <= 8'd0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            wid_q   <= wid_d;
            held_q  <= held_d;
            we_q    <= we_d;
            depth_q <= depth_d;
            width_q <= width_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign In_Ready     = ready;
    assign Write_Enable = we_q;
    assign Write_Depth  = depth_q;
    assign Write_Width  = width_q;
    assign Write_Data   = data_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

endmodule

// File: tb/tb_conv1d_2nd_data_ram_writer.sv
// Directed bench for conv1d_2nd_data_ram_writer (8 channels x 256 pooled samples).
// Inputs are driven 1 time unit after posedge; a negedge monitor logs writes and Done pulses.
// Each scenario task compares the log and outputs against hand-computed values.
module tb_conv1d_2nd_data_ram_writer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Start = 1'b0;
    logic        In_Valid = 1'b0;
    logic [15:0] In_Data = 16'd0;
    logic        In_Ready;
    logic        Write_Enable;
    logic [2:0]  Write_Depth;
    logic [7:0]  Write_Width;
    logic [15:0] Write_Data;
    logic        Busy;
    logic        Done;

    int tests = 0;
    int fails = 0;
    bit stalled = 0;

`ifdef POOL_RELU_EN
    localparam logic [15:0] EXP_NEG = 16'h0000;
`else
    localparam logic [15:0] EXP_NEG = 16'hFFFD;
`endif

    conv1d_2nd_data_ram_writer #(
        .Bit_width(16), .Num_Channels(8), .Out_Width(256)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .In_Valid(In_Valid), .In_Data(In_Data),
        .In_Ready(In_Ready), .Write_Enable(Write_Enable), .Write_Depth(Write_Depth),
        .Write_Width(Write_Width), .Write_Data(Write_Data), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    // Monitor log (only written here)
    logic [2:0]  q_dep[$];
    logic [7:0]  q_wid[$];
    logic [15:0] q_dat[$];
    bit          q_ok[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
    bit par = 0, prev_pair = 0, busy_prev = 0, busy_at_done = 0, busy_before_done = 0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        busy_prev <= Busy;
        if (!RST_N) begin
            par <= 1'b0;
            prev_pair <= 1'b0;
        end else begin
            if (Write_Enable) begin
                q_dep.push_back(Write_Depth);
                q_wid.push_back(Write_Width);
                q_dat.push_back(Write_Data);
                q_ok.push_back(prev_pair);
            end
            if (Done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                busy_at_done <= Busy;
                busy_before_done <= busy_prev;
            end
            prev_pair <= In_Valid && In_Ready && par;
            if (In_Valid && In_Ready) begin
                par <= ~par;
                last_xfer_cyc <= cyc;
            end
        end
    end

    function automatic logic [15:0] pat(input int k);
        int v;
        v = k * 40503 + 12345;
        return v[15:0];
    endfunction

    function automatic logic [15:0] pool_exp(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] m;
        m = ($signed(b) > $signed(a)) ? b : a;
`ifdef POOL_RELU_EN
        if (m[15]) m = 16'd0;
`endif
        return m;
    endfunction

    // Number of logged frame writes from base that differ from the model (pattern or running count).
    function automatic int frame_errors(input int base, input bit use_pat);
        int bad;
        logic [15:0] a, b, e;
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (base + i >= q_dat.size()) begin
                bad++;
            end else begin
                a = use_pat ? pat(2 * i) : 16'(2 * i);
                b = use_pat ? pat(2 * i + 1) : 16'(2 * i + 1);
                e = pool_exp(a, b);
                if (q_dep[base+i] !== 3'(i / 256) || q_wid[base+i] !== 8'(i % 256) ||
                    q_dat[base+i] !== e || q_ok[base+i] !== 1'b1)
                    bad++;
            end
        end
        return bad;
    endfunction

    task automatic send(input logic [15:0] d, input int gap);
        int n;
        if (stalled) return;
        In_Valid = 1'b1;
        In_Data = d;
        n = 0;
        forever begin
            @(negedge CLK);
            if (In_Ready) break;
            n++;
            if (n > 20) begin
                tests++; fails++;
                $display("FAIL send_timeout: In_Ready=%0b required 1", In_Ready);
                stalled = 1;
                In_Valid = 1'b0;
                return;
            end
        end
        @(posedge CLK); #1;
        if (gap > 0) begin
            In_Valid = 1'b0;
            repeat (gap) begin @(posedge CLK); #1; end
        end
    endtask

    task automatic start_pulse();
        @(posedge CLK); #1 Start = 1'b1;
        @(posedge CLK); #1 Start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST_N = 1'b0; In_Valid = 1'b0; Start = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
    endtask

    task automatic test_reset();
        In_Valid = 1'b1; In_Data = 16'h1234;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (5) begin @(posedge CLK); #1; end
        tests++; if (In_Ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b want 0", In_Ready); end
        tests++; if (Write_Enable !== 1'b0) begin fails++; $display("FAIL reset_we: got %0b want 0", Write_Enable); end
        tests++;
        if ({Write_Depth, Write_Width, Write_Data} !== 27'd0) begin
            fails++; $display("FAIL reset_addr_data: got %0d/%0d/%0h want 0/0/0", Write_Depth, Write_Width, Write_Data);
        end
        tests++; if ({Busy, Done} !== 2'b00) begin fails++; $display("FAIL reset_busy_done: got %b want 00", {Busy, Done}); end
        tests++; if (q_dat.size() !== 0) begin fails++; $display("FAIL reset_no_writes: got %0d writes want 0", q_dat.size()); end
        In_Valid = 1'b0;
    endtask

    task automatic test_basic_pooling();
        int base;
        base = q_dat.size();
        start_pulse();
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %0b want 1", Busy); end
        send(16'd5, 0); send(16'd9, 0);
        send(16'hFFFD, 0); send(16'hFFF9, 0);
        send(16'd4, 0); send(16'd4, 0);
        In_Valid = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        tests++;
        if (q_dat.size() - base !== 3) begin
            fails++; $display("FAIL basic_count: got %0d writes want 3", q_dat.size() - base);
        end else begin
            tests++;
            if ({q_dep[base], q_wid[base], q_dat[base]} !== {3'd0, 8'd0, 16'd9}) begin
                fails++; $display("FAIL basic_w0: got (%0d,%0d,%0h) want (0,0,9)", q_dep[base], q_wid[base], q_dat[base]);
            end
            tests++;
            if ({q_dep[base+1], q_wid[base+1], q_dat[base+1]} !== {3'd0, 8'd1, EXP_NEG}) begin
                fails++; $display("FAIL basic_w1: got (%0d,%0d,%0h) want (0,1,%0h)", q_dep[base+1], q_wid[base+1], q_dat[base+1], EXP_NEG);
            end
            tests++;
            if ({q_dep[base+2], q_wid[base+2], q_dat[base+2]} !== {3'd0, 8'd2, 16'd4}) begin
                fails++; $display("FAIL basic_w2: got (%0d,%0d,%0h) want (0,2,4)", q_dep[base+2], q_wid[base+2], q_dat[base+2]);
            end
        end
        tests++;
        if ({Write_Enable, Write_Width, Write_Data} !== {1'b0, 8'd2, 16'd4}) begin
            fails++; $display("FAIL basic_hold: got we=%0b w=%0d d=%0h want we=0 w=2 d=4", Write_Enable, Write_Width, Write_Data);
        end
        do_reset();
    endtask

    task automatic test_channel_wrap();
        int base, dbase, bad;
        base = q_dat.size();
        dbase = done_cnt;
        start_pulse();
        for (int k = 0; k < 4096; k++) send(16'(k), 0);
        In_Valid = 1'b0;
        repeat (6) begin @(posedge CLK); #1; end
        tests++;
        if (q_dat.size() - base !== 2048) begin
            fails++; $display("FAIL wrap_count: got %0d writes want 2048", q_dat.size() - base);
        end else begin
            tests++;
            if ({q_dep[base+255], q_wid[base+255], q_dep[base+256], q_wid[base+256]} !== {3'd0, 8'd255, 3'd1, 8'd0}) begin
                fails++; $display("FAIL wrap_chan: got (%0d,%0d)->(%0d,%0d) want (0,255)->(1,0)",
                                  q_dep[base+255], q_wid[base+255], q_dep[base+256], q_wid[base+256]);
            end
        end
        bad = frame_errors(base, 1'b0);
        tests++; if (bad !== 0) begin fails++; $display("FAIL wrap_data: got %0d bad writes want 0", bad); end
        tests++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - dbase); end
        tests++; if (done_cyc - last_xfer_cyc !== 2) begin fails++; $display("FAIL wrap_done_latency: got %0d want 2", done_cyc - last_xfer_cyc); end
        tests++;
        if ({busy_before_done, busy_at_done} !== 2'b10) begin
            fails++; $display("FAIL wrap_busy_fall: got %b want 10", {busy_before_done, busy_at_done});
        end
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL wrap_busy_after: got %0b want 0", Busy); end
    endtask

    task automatic test_backpressure_gaps();
        int base, dbase, bad;
        base = q_dat.size();
        dbase = done_cnt;
        start_pulse();
        for (int k = 0; k < 4096; k++) send(pat(k), int'($urandom_range(0, 5)));
        In_Valid = 1'b0;
        repeat (6) begin @(posedge CLK); #1; end
        tests++;
        if (q_dat.size() - base !== 2048) begin
            fails++; $display("FAIL gaps_count: got %0d writes want 2048", q_dat.size() - base);
        end
        bad = frame_errors(base, 1'b1);
        tests++; if (bad !== 0) begin fails++; $display("FAIL gaps_data: got %0d bad writes want 0", bad); end
        tests++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL gaps_done_count: got %0d want 1", done_cnt - dbase); end
    endtask

    task automatic test_reset_midframe();
        int base;
        base = q_dat.size();
        start_pulse();
        send(16'd10, 0); send(16'd20, 0); send(16'd30, 0);
        In_Valid = 1'b0;
        RST_N = 1'b0;
        #1;
        tests++;
        if ({In_Ready, Write_Enable, Write_Depth, Write_Width, Write_Data, Busy, Done} !== 31'd0) begin
            fails++; $display("FAIL midreset_zero: got rdy=%0b we=%0b d=%0d w=%0d dat=%0h busy=%0b done=%0b want all 0",
                              In_Ready, Write_Enable, Write_Depth, Write_Width, Write_Data, Busy, Done);
        end
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (4) begin @(posedge CLK); #1; end
        tests++;
        if (q_dat.size() - base !== 1) begin
            fails++; $display("FAIL midreset_count: got %0d writes want 1", q_dat.size() - base);
        end else begin
            tests++;
            if ({q_dep[base], q_wid[base], q_dat[base]} !== {3'd0, 8'd0, 16'd20}) begin
                fails++; $display("FAIL midreset_w0: got (%0d,%0d,%0d) want (0,0,20)", q_dep[base], q_wid[base], q_dat[base]);
            end
        end
        start_pulse();
        send(16'd7, 0); send(16'd3, 0);
        In_Valid = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        tests++;
        if (q_dat.size() - base !== 2) begin
            fails++; $display("FAIL restart_count: got %0d writes want 2", q_dat.size() - base);
        end else begin
            tests++;
            if ({q_dep[base+1], q_wid[base+1], q_dat[base+1]} !== {3'd0, 8'd0, 16'd7}) begin
                fails++; $display("FAIL restart_w0: got (%0d,%0d,%0d) want (0,0,7)", q_dep[base+1], q_wid[base+1], q_dat[base+1]);
            end
        end
        do_reset();
    endtask

    task automatic test_start_while_busy();
        int base, dbase, bad;
        base = q_dat.size();
        dbase = done_cnt;
        start_pulse();
        for (int k = 0; k < 4096; k++) begin
            if (k == 1000) Start = 1'b1;
            if (k == 1001) Start = 1'b0;
            send(16'(k), 0);
        end
        In_Valid = 1'b0;
        // Last pair was just accepted: the FSM is in its DONE state this cycle.
        Start = 1'b1;
        @(posedge CLK); #1 Start = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        bad = frame_errors(base, 1'b0);
        tests++; if (bad !== 0) begin fails++; $display("FAIL busy_start_data: got %0d bad writes want 0", bad); end
        tests++; if (q_dat.size() - base !== 2048) begin fails++; $display("FAIL busy_start_count: got %0d want 2048", q_dat.size() - base); end
        tests++; if (done_cnt - dbase !== 1) begin fails++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - dbase); end
        tests++;
        if ({Busy, In_Ready} !== 2'b00) begin
            fails++; $display("FAIL busy_start_idle: got busy/rdy=%b want 00", {Busy, In_Ready});
        end
        start_pulse();
        tests++;
        if ({Busy, In_Ready} !== 2'b11) begin
            fails++; $display("FAIL busy_start_new: got busy/rdy=%b want 11", {Busy, In_Ready});
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic_pooling();
        test_channel_wrap();
        test_backpressure_gaps();
        test_reset_midframe();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
